// File: rtl/flow_pop_pkg.sv
// flow_pop_pkg: shared FSM type and index helpers for the flow pop scheduler.
package flow_pop_pkg;

  // Widest one-hot vector onehot_to_idx accepts; callers zero-extend into it.
  localparam int unsigned MaxFlows = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } pop_state_t;

  // Width of a binary flow index, never less than one bit.
  function automatic int unsigned flow_idx_w(input int unsigned flows);
    int unsigned w;
    w = 1;
    if (flows > 1) begin
      w = $clog2(flows);
    end
    return w;
  endfunction

  // Binary index of the set bit of a one-hot vector; zero when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [MaxFlows-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxFlows; i++) begin
      if (oh[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_flow_arbiter.sv
// rr_flow_arbiter: picks one requesting flow per cycle, one-hot and binary.
// Build option FLOW_POP_STRICT_PRIO_EN: lowest index always wins and the pointer stays at 0.
module rr_flow_arbiter
  import flow_pop_pkg::*;
#(
  parameter int unsigned  FLOWS  = 10,
  localparam int unsigned FIDX_W = flow_idx_w(FLOWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOWS-1:0]  req,
  input  logic              advance,
  output logic [FLOWS-1:0]  grant,
  output logic [FIDX_W-1:0] grant_idx,
  output logic              any
);

  localparam int unsigned SUM_W = FIDX_W + 1;

  logic [FIDX_W-1:0] ptr_q;
  logic [FIDX_W-1:0] ptr_d;
  logic [FLOWS-1:0]  req_rot;
  logic [FIDX_W-1:0] off;
  logic [SUM_W-1:0]  sum;
  logic              found;

  // Rotate so bit 0 is the flow under the pointer; the lowest set bit is then the winner.
  assign req_rot = FLOWS'({req, req} >> ptr_q);

  // Find the first requester at or after the pointer and map it back to its flow number.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < FLOWS; i++) begin
      if (req_rot[i] && !found) begin
        found = 1'b1;
        off   = FIDX_W'(i);
      end
    end
    sum = SUM_W'(ptr_q) + SUM_W'(off);
    if (sum >= SUM_W'(FLOWS)) begin
      sum = sum - SUM_W'(FLOWS);
    end
    grant = '0;
    if (found) begin
      grant = FLOWS'(1) << sum;
    end
  end

  assign any       = |req;
  assign grant_idx = FIDX_W'(onehot_to_idx(MaxFlows'(grant)));

`ifdef FLOW_POP_STRICT_PRIO_EN
  // Search always starts at flow 0, which makes the rotation an identity.
  assign ptr_d = '0;
`else
  // Resume just after the flow that was granted, wrapping at the last flow.
  assign ptr_d = (grant_idx == FIDX_W'(FLOWS - 1)) ? '0 : grant_idx + FIDX_W'(1);
`endif

  // Pointer moves only when the grant is actually used.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && any) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/flow_pop_scheduler.sv
// flow_pop_scheduler: dequeue-side controller for the per-flow rank store.
// Tracks per-flow occupancy from the observed enqueue traffic, pops a non-empty flow,
// captures the store's reply and holds it on a valid/ready output.
// Build option FLOW_POP_STRICT_PRIO_EN: strict lowest-index priority instead of round-robin.
module flow_pop_scheduler
  import flow_pop_pkg::*;
#(
  parameter int unsigned  SIZE   = 50,
  parameter int unsigned  FLOWS  = 10,
  localparam int unsigned FIDX_W = flow_idx_w(FLOWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLOWS-1:0]  push_flow,
  output logic              pop,
  output logic [FLOWS-1:0]  pop_flow,
  input  logic [31:0]       pop_value,
  input  logic [31:0]       pop_rank,
  input  logic              pop_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_value,
  output logic [31:0]       out_rank,
  output logic [FIDX_W-1:0] out_flow,
  output logic [FLOWS-1:0]  flows_nonempty,
  output logic              overflow
);

  localparam int unsigned      CNT_W    = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pop_state_t        state_q;
  logic [CNT_W-1:0]  count_q [FLOWS];
  logic [CNT_W-1:0]  count_d [FLOWS];
  logic              overflow_d;
  logic [FLOWS-1:0]  eligible;
  logic [FLOWS-1:0]  grant;
  logic [FIDX_W-1:0] grant_idx;
  logic [FIDX_W-1:0] pend_idx_q;
  logic              any_eligible;
  logic              issue;

  // Eligibility uses registered counts only, so a same-cycle push never makes a flow
  // poppable and the store's empty-flow bypass path is never relied on.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < FLOWS; i++) begin
      eligible[i] = (count_q[i] != '0);
    end
  end

  assign flows_nonempty = eligible;

  rr_flow_arbiter #(
    .FLOWS (FLOWS)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .advance   (issue),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_eligible)
  );

  // Pop goes out from IDLE, or from HOLD in the very cycle the held entry is accepted.
  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      IDLE:    issue = any_eligible;
      HOLD:    issue = out_ready && any_eligible;
      default: issue = 1'b0;
    endcase
  end

  assign pop      = issue;
  assign pop_flow = issue ? grant : '0;

  // Occupancy: push without pop counts up (saturating, flagging overflow), pop without
  // push counts down, and a push and pop of the same flow cancel.
  always_comb begin
    overflow_d = overflow;
    for (int unsigned i = 0; i < FLOWS; i++) begin
      count_d[i] = count_q[i];
      if (push && push_flow[i] && !pop_flow[i]) begin
        if (count_q[i] == CNT_FULL) begin
          overflow_d = 1'b1;
        end else begin
          count_d[i] = count_q[i] + CNT_ONE;
        end
      end else if (!(push && push_flow[i]) && pop_flow[i]) begin
        count_d[i] = count_q[i] - CNT_ONE;
      end
    end
  end

  // Count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FLOWS; i++) begin
        count_q[i] <= '0;
      end
      overflow <= 1'b0;
    end else begin
      count_q  <= count_d;
      overflow <= overflow_d;
    end
  end

  // Control FSM with registered downstream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_idx_q <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_rank   <= '0;
      out_flow   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            pend_idx_q <= grant_idx;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // No timeout: a missing reply is a store protocol violation.
          if (pop_valid) begin
            out_value <= pop_value;
            out_rank  <= pop_rank;
            out_flow  <= pend_idx_q;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (issue) begin
              pend_idx_q <= grant_idx;
              state_q    <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_pop_scheduler.sv
// tb_flow_pop_scheduler: directed vector bench for flow_pop_scheduler.
module tb_flow_pop_scheduler;

  localparam int unsigned SIZE      = 50;
  localparam int unsigned FLOWS     = 10;
  localparam int unsigned FIDX_W    = 4;
  localparam logic [31:0] RSP_VALUE = 32'h0000_00AB;
  localparam logic [31:0] RSP_RANK  = 32'd7;

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic [FLOWS-1:0]  push_flow;
  logic              pop;
  logic [FLOWS-1:0]  pop_flow;
  logic [31:0]       pop_value;
  logic [31:0]       pop_rank;
  logic              pop_valid;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_value;
  logic [31:0]       out_rank;
  logic [FIDX_W-1:0] out_flow;
  logic [FLOWS-1:0]  flows_nonempty;
  logic              overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic push;
    int   pflow;
    logic rdy;
    logic e_pop;
    int   e_pf;
    logic e_ov;
    int   e_of;
    int   e_ne;   // -1: not checked
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  flow_pop_scheduler #(
    .SIZE  (SIZE),
    .FLOWS (FLOWS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_flow      (push_flow),
    .pop            (pop),
    .pop_flow       (pop_flow),
    .pop_value      (pop_value),
    .pop_rank       (pop_rank),
    .pop_valid      (pop_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_value      (out_value),
    .out_rank       (out_rank),
    .out_flow       (out_flow),
    .flows_nonempty (flows_nonempty),
    .overflow       (overflow)
  );

  // Rank store stand-in: answers every pop one cycle later.
  initial begin : store
    logic hit;
    pop_valid = 1'b0;
    pop_value = 32'hDEAD_BEEF;
    pop_rank  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      hit = pop;
      @(posedge clk);
      #1;
      pop_valid = hit;
      pop_value = hit ? RSP_VALUE : 32'hDEAD_BEEF;
      pop_rank  = hit ? RSP_RANK : 32'hDEAD_BEEF;
    end
  end

  function automatic logic [FLOWS-1:0] oh(input int f);
    return FLOWS'(1) << f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    push      = 1'b0;
    push_flow = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic p, input int pf, input logic r, input logic ep, input int epf,
                     input logic eov, input int eof, input int ene);
    vec_t v;
    v.push  = p;
    v.pflow = pf;
    v.rdy   = r;
    v.e_pop = ep;
    v.e_pf  = epf;
    v.e_ov  = eov;
    v.e_of  = eof;
    v.e_ne  = ene;
    vecs.push_back(v);
  endtask

  // One vector per cycle: drive just after the edge, compare 1 time unit later.
  task automatic run_vecs(input string tag);
    logic [15:0]       act;
    logic [15:0]       exp;
    logic [FLOWS-1:0]  epf;
    logic [FIDX_W-1:0] eof;
    logic [FIDX_W-1:0] aof;
    for (int i = 0; i < vecs.size(); i++) begin
      push      = vecs[i].push;
      push_flow = vecs[i].push ? oh(vecs[i].pflow) : '0;
      out_ready = vecs[i].rdy;
      #1;
      epf = vecs[i].e_pop ? oh(vecs[i].e_pf) : '0;
      eof = vecs[i].e_ov ? FIDX_W'(vecs[i].e_of) : '0;
      aof = vecs[i].e_ov ? out_flow : '0;
      exp = {vecs[i].e_pop, epf, vecs[i].e_ov, eof};
      act = {pop, pop_flow, out_valid, aof};
      check($sformatf("%s[%0d] {pop,pop_flow,out_valid,out_flow}", tag, i), 64'(act), 64'(exp));
      if (vecs[i].e_ov) begin
        check($sformatf("%s[%0d] {out_value,out_rank}", tag, i), {out_value, out_rank},
              {RSP_VALUE, RSP_RANK});
      end
      if (vecs[i].e_ne >= 0) begin
        check($sformatf("%s[%0d] flows_nonempty", tag, i), 64'(flows_nonempty),
              64'(vecs[i].e_ne));
      end
      tick();
    end
    vecs.delete();
  endtask

  initial begin : main
    int ord[6];
    int n0;
    int n1;
    int nx;
`ifdef FLOW_POP_STRICT_PRIO_EN
    ord = '{1, 1, 4, 4, 9, 9};
`else
    ord = '{1, 4, 9, 1, 4, 9};
`endif

    // Reset state, then a long idle stretch with nothing to pop.
    do_reset();
    #1;
    check("reset pop", 64'(pop), 64'(0));
    check("reset pop_flow", 64'(pop_flow), 64'(0));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_value/out_rank", {out_value, out_rank}, 64'(0));
    check("reset out_flow", 64'(out_flow), 64'(0));
    check("reset overflow", 64'(overflow), 64'(0));
    check("reset flows_nonempty", 64'(flows_nonempty), 64'(0));
    tick();
    for (int k = 0; k < 20; k++) add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    run_vecs("idle");

    // Single entry in flow 3.
    do_reset();
    add(1'b1, 3, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    add(1'b0, 0, 1'b1, 1'b1, 3, 1'b0, 0, 'h008);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 3, 0);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    run_vecs("single");

    // Flow 0 entry stalls in HOLD for 5 cycles while flows 1,4,9 fill, then drain.
    do_reset();
    add(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    add(1'b0, 0, 1'b0, 1'b1, 0, 1'b0, 0, 'h001);
    add(1'b1, 1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    add(1'b1, 4, 1'b0, 1'b0, 0, 1'b1, 0, 'h002);
    add(1'b1, 9, 1'b0, 1'b0, 0, 1'b1, 0, 'h012);
    add(1'b1, 1, 1'b0, 1'b0, 0, 1'b1, 0, 'h212);
    add(1'b1, 4, 1'b0, 1'b0, 0, 1'b1, 0, 'h212);
    add(1'b1, 9, 1'b0, 1'b0, 0, 1'b1, 0, 'h212);
    add(1'b0, 0, 1'b1, 1'b1, ord[0], 1'b1, 0, 'h212);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 'h212);
    for (int k = 0; k < 5; k++) begin
      add(1'b0, 0, 1'b1, 1'b1, ord[k+1], 1'b1, ord[k], -1);
      add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, -1);
    end
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, ord[5], 0);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    run_vecs("order");

    // Push and pop of flow 2 in the same cycle at count 1: a second pop must follow.
    do_reset();
    add(1'b1, 2, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    add(1'b1, 2, 1'b1, 1'b1, 2, 1'b0, 0, 'h004);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 'h004);
    add(1'b0, 0, 1'b1, 1'b1, 2, 1'b1, 2, 'h004);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 2, 0);
    add(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    run_vecs("pushpop");

    // Reset taken in the pop cycle: the reply that follows must be ignored.
    do_reset();
    push      = 1'b1;
    push_flow = oh(5);
    out_ready = 1'b1;
    tick();
    push = 1'b0;
    #1;
    check("rstmid pop", {63'(pop_flow), pop}, {63'(oh(5)), 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid after reset", {62'(flows_nonempty), pop, out_valid}, 64'(0));
    tick();
    #1;
    check("rstmid reply ignored", {62'(flows_nonempty), pop, out_valid}, 64'(0));
    tick();

    // Overflow: park flow 1 in HOLD, fill flow 0 to SIZE, then one more push.
    do_reset();
    push      = 1'b1;
    push_flow = oh(1);
    tick();
    push = 1'b0;
    tick();
    push_flow = oh(0);
    for (int k = 0; k < int'(SIZE); k++) begin
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    #1;
    check("overflow after SIZE pushes", 64'(overflow), 64'(0));
    check("nonempty after SIZE pushes", 64'(flows_nonempty), 64'(1));
    tick();
    push = 1'b1;
    tick();
    push = 1'b0;
    #1;
    check("overflow after SIZE+1 pushes", 64'(overflow), 64'(1));
    tick();
    out_ready = 1'b1;
    n0 = 0;
    n1 = 0;
    nx = 0;
    for (int k = 0; k < 2 * int'(SIZE) + 20; k++) begin
      #1;
      if (out_valid) begin
        if (out_flow == 0) n0++;
        else if (out_flow == 1) n1++;
        else nx++;
      end
      tick();
    end
    #1;
    check("drained flow 0 entries", 64'(n0), 64'(SIZE));
    check("drained flow 1 entries", 64'(n1), 64'(1));
    check("drained other entries", 64'(nx), 64'(0));
    check("nonempty after drain", 64'(flows_nonempty), 64'(0));
    check("overflow sticky", 64'(overflow), 64'(1));
    do_reset();
    #1;
    check("overflow cleared by reset", 64'(overflow), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
